spart_rx_core: RTL

Parametrised SPART receive channel: oversampled asynchronous serial receiver with runtime baud divisor, optional parity, and a show-ahead receive FIFO carrying per-character error status. It sits between the `rxd` pin and the SPART bus interface, replacing the fixed 8N1 single-buffer receiver. Characters are framed LSB first, with one start bit, DATA_BITS data bits, an optional parity bit and one stop bit.

---
 rtl/spart_rx_core.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spart_rx_core.sv
// SPART receive channel: oversampled async serial receiver with runtime baud divisor
// and a show-ahead receive FIFO. Define SPART_RX_PARITY_EN to build the parity bit support.
module spart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic [15:0]                   baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          rda,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
`ifdef SPART_RX_PARITY_EN
  localparam int EW = DATA_BITS + 2;
`else
  localparam int EW = DATA_BITS + 1;
`endif
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BITS_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SPART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  state_t                state_r, state_n;
  logic                  sync1_r, sync2_r, rxd_d_r;
  logic                  rxd_s, fall_s;
  logic [15:0]           cnt_r;
  logic                  tick_s;
  logic [TW-1:0]         tcnt_r;
  logic                  samp_s;
  logic [3:0]            bcnt_r;
  logic [DATA_BITS-1:0]  shift_r;
  logic                  data_smp_s, stop_smp_s;
  logic                  push_r;
  logic [EW-1:0]         entry_r;
  logic [EW-1:0]         mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wptr_r, rptr_r;
  logic [CW-1:0]         count_r;
  logic                  overrun_r;
  logic                  pop_s, full_s, wr_s, drop_s;
  logic [EW-1:0]         head_s;
`ifdef SPART_RX_PARITY_EN
  logic                  par_smp_s, par_en_s, odd_s, perr_r;
  assign par_en_s = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign odd_s    = (parity_mode == 2'b10);
`else
  logic                  unused_parity_s;
  assign unused_parity_s = ^parity_mode;
`endif

  assign rxd_s  = sync2_r;
  assign fall_s = rxd_d_r & ~sync2_r;
  assign tick_s = (state_r != IDLE) && (cnt_r == 16'd0);
  assign samp_s = tick_s && (tcnt_r == ((state_r == START) ? HALF_LAST : FULL_LAST));

  // rxd synchroniser plus one delay stage for start-edge detection; idle level is 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      rxd_d_r <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
      rxd_d_r <= sync2_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next state and sample strobes
  always_comb begin
    state_n    = state_r;
    data_smp_s = 1'b0;
    stop_smp_s = 1'b0;
`ifdef SPART_RX_PARITY_EN
    par_smp_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (fall_s) state_n = START;
        else        state_n = IDLE;
      end
      START: begin
        if (samp_s) begin
          if (rxd_s) state_n = IDLE;
          else       state_n = DATA;
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (samp_s) begin
          data_smp_s = 1'b1;
          if (bcnt_r == BITS_LAST) begin
`ifdef SPART_RX_PARITY_EN
            if (par_en_s) state_n = PARITY;
            else          state_n = STOP;
`else
            state_n = STOP;
`endif
          end else begin
            state_n = DATA;
          end
        end else begin
          state_n = DATA;
        end
      end
`ifdef SPART_RX_PARITY_EN
      PARITY: begin
        if (samp_s) begin
          par_smp_s = 1'b1;
          state_n   = STOP;
        end else begin
          state_n = PARITY;
        end
      end
`endif
      STOP: begin
        if (samp_s) begin
          stop_smp_s = 1'b1;
          state_n    = IDLE;
        end else begin
          state_n = STOP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Baud tick divider and per-bit tick counter; divider is held at baud_div while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= 16'd0;
      tcnt_r <= {TW{1'b0}};
    end else begin
      if (state_r == IDLE || cnt_r == 16'd0) cnt_r <= baud_div;
      else                                   cnt_r <= cnt_r - 16'd1;
      if (state_r == IDLE || samp_s) tcnt_r <= {TW{1'b0}};
      else if (tick_s)               tcnt_r <= tcnt_r + TW'(1);
    end
  end

  // Character assembly; the entry is pushed on the cycle after the stop sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_r  <= 4'd0;
      shift_r <= {DATA_BITS{1'b0}};
      push_r  <= 1'b0;
      entry_r <= {EW{1'b0}};
`ifdef SPART_RX_PARITY_EN
      perr_r  <= 1'b0;
`endif
    end else begin
      if (state_r != DATA)  bcnt_r <= 4'd0;
      else if (data_smp_s)  bcnt_r <= bcnt_r + 4'd1;
      if (data_smp_s) shift_r <= {rxd_s, shift_r[DATA_BITS-1:1]};
      push_r <= stop_smp_s;
`ifdef SPART_RX_PARITY_EN
      if (state_r == START) perr_r <= 1'b0;
      else if (par_smp_s)   perr_r <= ((parity_of(shift_r) ^ rxd_s) != odd_s);
      if (stop_smp_s) entry_r <= {perr_r, ~rxd_s, shift_r};
`else
      if (stop_smp_s) entry_r <= {~rxd_s, shift_r};
`endif
    end
  end

  assign pop_s  = rd_en && (count_r != {CW{1'b0}});
  assign full_s = (count_r == CW'(FIFO_DEPTH));
  assign wr_s   = push_r && (!full_s || pop_s);
  assign drop_s = push_r && full_s && !pop_s;

  // Receive FIFO storage, pointers, occupancy and sticky overrun (set wins over clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {EW{1'b0}};
      wptr_r    <= {AW{1'b0}};
      rptr_r    <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wptr_r] <= entry_r;
        wptr_r        <= wptr_r + AW'(1);
      end
      if (pop_s) rptr_r <= rptr_r + AW'(1);
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s)     overrun_r <= 1'b1;
      else if (pop_s) overrun_r <= 1'b0;
    end
  end

  assign head_s     = mem_r[rptr_r];
  assign rda        = (count_r != {CW{1'b0}});
  assign rx_data    = rda ? head_s[DATA_BITS-1:0] : {DATA_BITS{1'b0}};
  assign frame_err  = rda & head_s[DATA_BITS];
`ifdef SPART_RX_PARITY_EN
  assign parity_err = rda & head_s[DATA_BITS+1];
`else
  assign parity_err = 1'b0;
`endif
  assign fifo_count = count_r;
  assign overrun    = overrun_r;

endmodule
